approx_mul_ha_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8x8 half-adder-array approximate multipliers.
- Generates WIDTH x WIDTH unsigned partial products and pairs adjacent rows.
- Compresses each pair with a half-adder array; the low columns use a configurable approximate cell.
- Sums the compressed rows into a registered product with a valid/ready handshake.
- Sits between operand producers and the accumulator datapath; mode is selectable per transaction.

---
 rtl/approx_mul_pkg.sv | 27 ++
 rtl/approx_mul_ha_pipe_ha_pair_row.sv | 37 +++
 rtl/approx_mul_ha_pipe.sv | 156 +++++++++++++++
 tb/tb_approx_mul_ha_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared cell-mode enum, row-pair type and cell selection
// for approx_mul_ha_pipe.
package approx_mul_pkg;

   typedef enum logic {
      CELL_EXACT,
      CELL_OR
   } cell_mode_e;

   localparam int DEF_WIDTH = 8;
   localparam int ROW_W     = DEF_WIDTH + 1;

   typedef struct packed {
      logic [ROW_W-1:0] sum;
      logic [ROW_W-1:0] carry;
   } pair_row_t;

   function automatic cell_mode_e cell_mode(
      input int   k,
      input int   c,
      input logic approx,
      input int   approx_cols
   );
      return (approx && ((2 * k + c) < approx_cols)) ? CELL_OR : CELL_EXACT;
   endfunction

endpackage

// File: rtl/approx_mul_ha_pipe_ha_pair_row.sv
// ha_pair_row: half-adder cell array compressing one pair of adjacent
// partial-product rows; low absolute columns may use the OR cell.
module ha_pair_row
   import approx_mul_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int PAIR_IDX    = 0,
   parameter int APPROX_COLS = 6
) (
   input  logic             i_approx,
   input  logic [WIDTH-1:0] i_top,
   input  logic [WIDTH-1:0] i_bot,
   output logic [WIDTH:0]   o_sum,
   output logic [WIDTH:0]   o_carry
);

   logic [WIDTH:0] w_a;
   logic [WIDTH:0] w_d;

   // bottom row sits one column left of the top row
   assign w_a = {1'b0, i_top};
   assign w_d = {i_bot, 1'b0};

   always_comb begin
      o_sum   = '0;
      o_carry = '0;
      for (int c = 0; c <= WIDTH; c++) begin
         if (cell_mode(PAIR_IDX, c, i_approx, APPROX_COLS) == CELL_OR) begin
            o_sum[c] = w_a[c] | w_d[c];
         end else begin
            o_sum[c]   = w_a[c] ^ w_d[c];
            o_carry[c] = w_a[c] & w_d[c];
         end
      end
   end

endmodule

// File: rtl/approx_mul_ha_pipe.sv
// approx_mul_ha_pipe: 3-stage approximate half-adder-array multiplier.
// Optional stats counters under `APPROX_MUL_STATS_EN.
module approx_mul_ha_pipe
   import approx_mul_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 6,
   parameter int TAG_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic               in_approx,
   input  logic [TAG_W-1:0]   in_tag,
`ifdef APPROX_MUL_STATS_EN
   input  logic               stat_clr,
   output logic [31:0]        stat_total,
   output logic [31:0]        stat_mismatch,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int NPAIR = WIDTH / 2;
   localparam int P_W   = 2 * WIDTH;

   typedef struct packed {
      logic [WIDTH:0] sum;
      logic [WIDTH:0] carry;
   } row_pair_t;

   logic             w_adv;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_x;
   logic [WIDTH-1:0] r_s1_y;
   logic             r_s1_approx;
   logic [TAG_W-1:0] r_s1_tag;
   row_pair_t        w_row [NPAIR];
   row_pair_t        r_s2_row [NPAIR];
   logic             r_s2_valid;
   logic [TAG_W-1:0] r_s2_tag;
   logic [P_W-1:0]   w_sum;
   logic             r_s3_valid;
   logic [P_W-1:0]   r_s3_p;
   logic [TAG_W-1:0] r_s3_tag;

   // single global enable: the whole pipe moves unless the output is stuck
   assign w_adv    = out_ready | ~r_s3_valid;
   assign in_ready = ~rst & w_adv;

   for (genvar k = 0; k < NPAIR; k++) begin : g_pair
      ha_pair_row #(
         .WIDTH       (WIDTH),
         .PAIR_IDX    (k),
         .APPROX_COLS (APPROX_COLS)
      ) u_row (
         .i_approx (r_s1_approx),
         .i_top    (r_s1_x & {WIDTH{r_s1_y[2*k]}}),
         .i_bot    (r_s1_x & {WIDTH{r_s1_y[2*k+1]}}),
         .o_sum    (w_row[k].sum),
         .o_carry  (w_row[k].carry)
      );
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NPAIR; k++) begin
         w_sum = w_sum
               + (P_W'(r_s2_row[k].sum) << (2 * k))
               + (P_W'(r_s2_row[k].carry) << (2 * k + 1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s1_approx <= 1'b0;
         r_s1_tag    <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_tag    <= '0;
         for (int k = 0; k < NPAIR; k++) begin
            r_s2_row[k] <= '0;
         end
         r_s3_valid  <= 1'b0;
         r_s3_p      <= '0;
         r_s3_tag    <= '0;
      end else if (w_adv) begin
         r_s1_valid  <= in_valid;
         r_s1_x      <= in_x;
         r_s1_y      <= in_y;
         r_s1_approx <= in_approx;
         r_s1_tag    <= in_tag;
         r_s2_valid  <= r_s1_valid;
         r_s2_tag    <= r_s1_tag;
         for (int k = 0; k < NPAIR; k++) begin
            r_s2_row[k] <= w_row[k];
         end
         r_s3_valid  <= r_s2_valid;
         r_s3_p      <= w_sum;
         r_s3_tag    <= r_s2_tag;
      end
   end

   assign out_valid = r_s3_valid;
   assign out_p     = r_s3_p;
   assign out_tag   = r_s3_tag;

`ifdef APPROX_MUL_STATS_EN
   logic [P_W-1:0] r_s2_exact;
   logic [P_W-1:0] r_s3_exact;
   logic [31:0]    r_total;
   logic [31:0]    r_mismatch;
   logic           w_hs;

   assign w_hs = r_s3_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_exact <= '0;
         r_s3_exact <= '0;
      end else if (w_adv) begin
         r_s2_exact <= P_W'(r_s1_x) * P_W'(r_s1_y);
         r_s3_exact <= r_s2_exact;
      end
   end

   // clear wins over a same-cycle increment; both counters saturate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_total    <= '0;
         r_mismatch <= '0;
      end else if (stat_clr) begin
         r_total    <= '0;
         r_mismatch <= '0;
      end else if (w_hs) begin
         if (r_total != '1) begin
            r_total <= r_total + 32'd1;
         end
         if ((r_s3_p != r_s3_exact) && (r_mismatch != '1)) begin
            r_mismatch <= r_mismatch + 32'd1;
         end
      end
   end

   assign stat_total    = r_total;
   assign stat_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// tb_approx_mul_ha_pipe: scoreboard bench for approx_mul_ha_pipe with
// APPROX_COLS=6 and APPROX_COLS=0 instances driven in lockstep.
module tb_approx_mul_ha_pipe;

   localparam int W  = 8;
   localparam int TW = 4;

   typedef struct {
      logic [2*W-1:0] p;
      logic [TW-1:0]  tag;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic          in_approx;
   logic [TW-1:0] in_tag;
   logic          out_ready;
   logic          in_ready, in_ready0;
   logic          out_valid, out_valid0;
   logic [2*W-1:0] out_p, out_p0;
   logic [TW-1:0]  out_tag, out_tag0;
`ifdef APPROX_MUL_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_total, stat_mismatch;
   logic [31:0] stat_total0, stat_mismatch0;
`endif

   exp_t q6[$];
   exp_t q0[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   last_acc;
   bit   ovr_en = 1'b0;
   int   ovr_p  = 0;

   always #5 clk = ~clk;

   approx_mul_ha_pipe #(.WIDTH(W), .APPROX_COLS(6), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_approx (in_approx),
      .in_tag    (in_tag),
`ifdef APPROX_MUL_STATS_EN
      .stat_clr      (stat_clr),
      .stat_total    (stat_total),
      .stat_mismatch (stat_mismatch),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag)
   );

   approx_mul_ha_pipe #(.WIDTH(W), .APPROX_COLS(0), .TAG_W(TW)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_approx (in_approx),
      .in_tag    (in_tag),
`ifdef APPROX_MUL_STATS_EN
      .stat_clr      (stat_clr),
      .stat_total    (stat_total0),
      .stat_mismatch (stat_mismatch0),
`endif
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_p     (out_p0),
      .out_tag   (out_tag0)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int model(input int x, input int y, input bit ap,
                                input int acols);
      int p;
      p = 0;
      for (int k = 0; k < W / 2; k++) begin
         for (int c = 0; c <= W; c++) begin
            int a, d, s, cy, col;
            a   = (c < W) ? (((y >> (2 * k)) & 1) & ((x >> c) & 1)) : 0;
            d   = (c > 0) ? (((y >> (2 * k + 1)) & 1) & ((x >> (c - 1)) & 1)) : 0;
            col = 2 * k + c;
            if (ap && col < acols) begin
               s  = a | d;
               cy = 0;
            end else begin
               s  = a ^ d;
               cy = a & d;
            end
            p = p + (s << col) + (cy << (col + 1));
         end
      end
      return p;
   endfunction

   // called just after a negedge with inputs already set
   task automatic cycle();
      exp_t e;
      #1;
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         e.p   = ovr_en ? (2*W)'(ovr_p) : (2*W)'(model(in_x, in_y, in_approx, 6));
         e.tag = in_tag;
         q6.push_back(e);
      end
      if (in_valid && in_ready0) begin
         e.p   = (2*W)'(int'(in_x) * int'(in_y));
         e.tag = in_tag;
         q0.push_back(e);
      end
      if (out_valid && out_ready) begin
         if (q6.size() == 0) begin
            chk("spurious6", 32'd1, 32'd0);
         end else begin
            e = q6.pop_front();
            chk("p6", 32'(out_p), 32'(e.p));
            chk("tag6", 32'(out_tag), 32'(e.tag));
         end
      end
      if (out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            chk("spurious0", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("p0", 32'(out_p0), 32'(e.p));
            chk("tag0", 32'(out_tag0), 32'(e.tag));
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive(input int x, input int y, input bit ap,
                        input int tag);
      in_valid  = 1'b1;
      in_x      = W'(x);
      in_y      = W'(y);
      in_approx = ap;
      in_tag    = TW'(tag);
   endtask

   task automatic drain();
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q6.size() != 0 || q0.size() != 0) && n < 40) begin
         cycle();
         n++;
      end
      chk("drain_empty", 32'(q6.size() + q0.size()), 32'd0);
   endtask

   initial begin
      int acc_cyc, n, sent;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_approx = 1'b0;
      in_tag    = '0;
      out_ready = 1'b1;
`ifdef APPROX_MUL_STATS_EN
      stat_clr  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_p", 32'(out_p), 32'd0);
      chk("rst_tag", 32'(out_tag), 32'd0);
      chk("rst_iready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_iready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // exact 255x255 with latency measurement
      drive(255, 255, 1'b0, 'hA);
      ovr_en  = 1'b1;
      ovr_p   = 65025;
      acc_cyc = cyc;
      cycle();
      chk("acc_lat", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      ovr_en   = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         cycle();
         n++;
      end
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("latency", 32'(cyc - acc_cyc), 32'd3);
      drain();

      // 3x3 approximate then exact, back to back
      ovr_en = 1'b1;
      drive(3, 3, 1'b1, 1);
      ovr_p = 7;
      cycle();
      drive(3, 3, 1'b0, 2);
      ovr_p = 9;
      cycle();
      ovr_en = 1'b0;
      drain();

      // backpressure: three accepted, output held
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0, 255), $urandom_range(0, 255),
               1'($urandom_range(0, 1)), i + 4);
         cycle();
         chk("bp_acc", 32'(last_acc), 32'd1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_iready", 32'(in_ready), 32'd0);
         chk("bp_ovalid", 32'(out_valid), 32'd1);
         chk("bp_p", 32'(out_p), 32'(q6[0].p));
         chk("bp_tag", 32'(out_tag), 32'(q6[0].tag));
         cycle();
      end
      drain();

      // reset with transactions in flight
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0, 255), $urandom_range(0, 255), 1'b1, i + 8);
         cycle();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_ovalid", 32'(out_valid), 32'd0);
      chk("mrst_iready", 32'(in_ready), 32'd0);
      chk("mrst_p", 32'(out_p), 32'd0);
      q6.delete();
      q0.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("mrst_stale", 32'(out_valid | out_valid0), 32'd0);
         cycle();
      end

`ifdef APPROX_MUL_STATS_EN
      chk("st_total0", stat_total, 32'd0);
      ovr_en = 1'b1;
      drive(3, 3, 1'b1, 1);
      ovr_p = 7;
      cycle();
      drive(3, 3, 1'b0, 2);
      ovr_p = 9;
      cycle();
      ovr_en = 1'b0;
      drain();
      chk("st_total", stat_total, 32'd2);
      chk("st_mism", stat_mismatch, 32'd1);
      stat_clr = 1'b1;
      cycle();
      stat_clr = 1'b0;
      chk("st_clr_total", stat_total, 32'd0);
      chk("st_clr_mism", stat_mismatch, 32'd0);
`endif

      // random approximate traffic with random stalls
      sent = 0;
      n    = 0;
      while (sent < 1000 && n < 20000) begin
         in_valid  = ($urandom_range(0, 4) != 0);
         in_x      = W'($urandom_range(0, 255));
         in_y      = W'($urandom_range(0, 255));
         in_approx = 1'b1;
         in_tag    = TW'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         if (last_acc) sent++;
         n++;
      end
      chk("rand_sent", 32'(sent), 32'd1000);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
